// File: rtl/sub_bytes_pipe.sv
// rtl/sub_bytes_pipe.sv - pipelined multi-lane AES SubBytes/InvSubBytes unit
//
// Applies the FIPS-197 S-box (or inverse S-box) independently to LANES bytes
// per transfer. The lookup is registered in stage 1; stages 2..LAT are pure
// delay registers. Bubbles collapse: an empty stage always accepts from its
// predecessor, so in_ready drops only when every stage is full and the
// output is stalled.
//
// Optional macro SUB_BYTES_INV_EN: when defined, in_mode=1 selects the
// inverse S-box and out_mode echoes the sampled mode. When undefined, the
// inverse table is omitted, in_mode is ignored and out_mode is always 0.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   input word valid
//   in_ready   unit can accept an input word this cycle
//   in_mode    0 = forward S-box, 1 = inverse S-box (sampled with in_data)
//   in_data    LANES bytes, lane i = bits [8i+7:8i]
//   out_valid  output word valid
//   out_ready  downstream accepts the output word
//   out_mode   mode the presented word was processed with
//   out_data   substituted bytes, same lane order
//   busy       any pipeline stage holds a valid word

module sub_bytes_pipe #(
    parameter int LANES = 16,
    parameter int LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [8*LANES-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_mode,
    output logic [8*LANES-1:0]   out_data,
    output logic                 busy
);

    localparam int W = 8 * LANES;

    // Byte b of the table lives at bits [(255-b)*8 +: 8], i.e. entry 0x00 is
    // the most significant byte so the rows read in the usual table order.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777b_f26b6fc5_3001672b_fed7ab76,
        128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
        128'h04c723c3_1896059a_071280e2_eb27b275,
        128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
        128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
        128'hd0efaafb_434d3385_45f9027f_503c9fa8,
        128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
        128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
        128'h60814fdc_222a9088_46eeb814_de5e0bdb,
        128'he0323a0a_4906245c_c2d3ac62_9195e479,
        128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
        128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
        128'h703eb566_4803f60e_613557b9_86c11d9e,
        128'he1f89811_69d98e94_9b1e87e9_ce5528df,
        128'h8ca1890d_bfe64268_41992d0f_b054bb16
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        sbox_fwd = SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

`ifdef SUB_BYTES_INV_EN
    localparam logic [2047:0] INV_SBOX_TABLE = {
        128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
        128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
        128'h547b9432_a6c2233d_ee4c950b_42fac34e,
        128'h082ea166_28d924b2_765ba249_6d8bd125,
        128'h72f8f664_86689816_d4a45ccc_5d65b692,
        128'h6c704850_fdedb9da_5e154657_a78d9d84,
        128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
        128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
        128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
        128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
        128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
        128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
        128'h1fdda833_8807c731_b1121059_2780ec5f,
        128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
        128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
        128'h172b047e_ba77d626_e1691463_55210c7d
    };

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        sbox_inv = INV_SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction
`endif

    // Pipeline state, stage 1 is nearest the input, stage LAT drives out_*.
    logic [LAT:1] v_q,    v_d;
    logic [LAT:1] mode_q, mode_d;
    logic [W-1:0] data_q [1:LAT];
    logic [W-1:0] data_d [1:LAT];

    logic [LAT:1] adv;
    logic         in_fire;
    logic         mode_in;
    logic [W-1:0] lut_data;

`ifdef SUB_BYTES_INV_EN
    assign mode_in = in_mode;
`else
    // Forward-only build: mode input has no effect on the datapath.
    logic unused_in_mode;
    assign unused_in_mode = in_mode;
    assign mode_in        = 1'b0;
`endif

    // A stage may load when it is empty or its successor is moving; the chain
    // runs from the output back so a single out_ready ripples to the input.
    always_comb begin
        adv      = '0;
        adv[LAT] = !v_q[LAT] || out_ready;
        for (int k = LAT - 1; k >= 1; k--) begin
            adv[k] = !v_q[k] || adv[k+1];
        end
    end

    assign in_ready = adv[1];
    assign in_fire  = in_valid && adv[1];

    // Per-lane independent lookup feeding the stage-1 register.
    always_comb begin
        lut_data = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef SUB_BYTES_INV_EN
            lut_data[8*i +: 8] = mode_in ? sbox_inv(in_data[8*i +: 8])
                                         : sbox_fwd(in_data[8*i +: 8]);
`else
            lut_data[8*i +: 8] = sbox_fwd(in_data[8*i +: 8]);
`endif
        end
    end

    // Payload only changes when a valid word moves in, so out_data keeps its
    // last value while the output is idle and bubbles never disturb it.
    always_comb begin
        v_d    = v_q;
        mode_d = mode_q;
        for (int k = 1; k <= LAT; k++) begin
            data_d[k] = data_q[k];
        end

        if (adv[1]) begin
            v_d[1] = in_fire;
            if (in_fire) begin
                mode_d[1] = mode_in;
                data_d[1] = lut_data;
            end
        end

        for (int k = 2; k <= LAT; k++) begin
            if (adv[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    mode_d[k] = mode_q[k-1];
                    data_d[k] = data_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q    <= '0;
            mode_q <= '0;
            for (int k = 1; k <= LAT; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            v_q    <= v_d;
            mode_q <= mode_d;
            for (int k = 1; k <= LAT; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign out_valid = v_q[LAT];
    assign out_mode  = mode_q[LAT];
    assign out_data  = data_q[LAT];
    assign busy      = |v_q;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// tb/tb_sub_bytes_pipe.sv - self-checking bench for sub_bytes_pipe

module tb_sub_bytes_pipe;

    localparam int LANES = 16;
    localparam int LAT   = 2;
    localparam int W     = 8 * LANES;

`ifdef SUB_BYTES_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_mode   = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic         out_mode;
    logic [W-1:0] out_data;
    logic         busy;

    sub_bytes_pipe #(.LANES(LANES), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference S-boxes derived from GF(2^8) arithmetic.
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    typedef struct {
        logic [W-1:0] data;
        logic         mode;
        int           age;
    } entry_t;

    entry_t       pipe_q [$];
    logic [W:0]   emit_log [$];
    logic [W-1:0] last_shown = '0;
    int           n_acc  = 0;
    int           n_emit = 0;
    int           n_both = 0;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] model_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [W-1:0] exp_word(input logic [W-1:0] d, input logic m);
        logic [W-1:0] r;
        logic [7:0]   b;
        for (int i = 0; i < LANES; i++) begin
            b = d[8*i +: 8];
            r[8*i +: 8] = (m && INV_EN) ? inv_tab[b] : fwd_tab[b];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[8*i +: 8] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare against the model a
    // little later, update the model with the transfers that the handshake
    // rules imply, then step through the rising edge.
    task automatic cycle(input logic iv, input logic [W-1:0] id, input logic im, input logic ordy);
        logic   mv;
        logic   mir;
        logic   acc;
        logic   emit;
        entry_t e;
        in_valid  = iv;
        in_data   = id;
        in_mode   = im;
        out_ready = ordy;
        #1;
        mv  = (pipe_q.size() > 0) && (pipe_q[0].age >= LAT);
        mir = !((pipe_q.size() == LAT) && !ordy);
        check("out_valid", {127'b0, out_valid}, {127'b0, mv});
        check("in_ready",  {127'b0, in_ready},  {127'b0, mir});
        check("busy",      {127'b0, busy},      {127'b0, pipe_q.size() > 0});
        if (mv) begin
            last_shown = pipe_q[0].data;
            check("out_mode", {127'b0, out_mode}, {127'b0, pipe_q[0].mode});
        end
        check("out_data", out_data, last_shown);
        acc  = iv && mir;
        emit = mv && ordy;
        if (emit) begin
            emit_log.push_back({out_mode, out_data});
            void'(pipe_q.pop_front());
            n_emit++;
        end
        if (acc) begin
            e.data = exp_word(id, im);
            e.mode = INV_EN ? im : 1'b0;
            e.age  = 0;
            pipe_q.push_back(e);
            n_acc++;
        end
        if (acc && emit) n_both++;
        @(posedge clk);
        foreach (pipe_q[i]) pipe_q[i].age = pipe_q[i].age + 1;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pipe_q.delete();
        last_shown = '0;
        #1;
        check("rst_out_valid", {127'b0, out_valid}, 128'd0);
        check("rst_busy",      {127'b0, busy},      128'd0);
        check("rst_out_data",  out_data,            '0);
        check("rst_out_mode",  {127'b0, out_mode},  128'd0);
        check("rst_in_ready",  {127'b0, in_ready},  128'd1);
    endtask

    logic [W-1:0] vec;
    logic [W:0]   ent;
    logic [7:0]   kb;

    initial begin
        for (int i = 0; i < 256; i++) fwd_tab[i] = model_sbox(8'(i));
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

        @(negedge clk);
        do_reset(2);

        // Forward known-answer lanes.
        vec = rand_word();
        vec[7:0]     = 8'h00;
        vec[15:8]    = 8'h53;
        vec[127:120] = 8'hFF;
        emit_log.delete();
        cycle(1'b1, vec, 1'b0, 1'b1);
        repeat (LAT + 1) cycle(1'b0, rand_word(), 1'($urandom_range(0, 1)), 1'b1);
        check("kat_fwd_count", 128'(emit_log.size()), 128'd1);
        ent = emit_log[0];
        check("kat_fwd_lane0",  {120'b0, ent[7:0]},     128'h63);
        check("kat_fwd_lane1",  {120'b0, ent[15:8]},    128'hED);
        check("kat_fwd_lane15", {120'b0, ent[127:120]}, 128'h16);

        // Inverse known-answer lanes (forward results when inverse is absent).
        vec = rand_word();
        vec[7:0]   = 8'h63;
        vec[15:8]  = 8'hED;
        vec[23:16] = 8'h16;
        emit_log.delete();
        cycle(1'b1, vec, 1'b1, 1'b1);
        repeat (LAT + 1) cycle(1'b0, '0, 1'b0, 1'b1);
        ent = emit_log[0];
        check("kat_inv_lane0", {120'b0, ent[7:0]},   INV_EN ? 128'h00 : 128'hFB);
        check("kat_inv_lane1", {120'b0, ent[15:8]},  INV_EN ? 128'h53 : 128'h55);
        check("kat_inv_lane2", {120'b0, ent[23:16]}, INV_EN ? 128'hFF : 128'h47);
        check("kat_inv_mode",  {127'b0, ent[W]},     INV_EN ? 128'd1  : 128'd0);

        // Streaming: 256 back-to-back words; one bubble would leave a word behind.
        n_emit = 0;
        emit_log.delete();
        for (int k = 0; k < 256; k++) begin
            kb = 8'(k);
            cycle(1'b1, {LANES{kb}}, 1'b0, 1'b1);
        end
        repeat (LAT) cycle(1'b0, '0, 1'b0, 1'b1);
        check("stream_count", 128'(n_emit), 128'd256);
        ent = emit_log[255];
        check("stream_last", ent[W-1:0], {LANES{8'h16}});
        ent = emit_log[0];
        check("stream_first", ent[W-1:0], {LANES{8'h63}});

        // Backpressure: only LAT words fit, then full-pipe accept-with-emit.
        n_acc = 0;
        repeat (6) cycle(1'b1, rand_word(), 1'b0, 1'b0);
        check("bp_accepts", 128'(n_acc), 128'(LAT));
        n_both = 0;
        repeat (4) cycle(1'b1, rand_word(), 1'b0, 1'b1);
        check("bp_accept_emit", 128'(n_both), 128'd4);
        repeat (LAT + 1) cycle(1'b0, '0, 1'b0, 1'b1);

        // Alternating modes with no turnaround.
        emit_log.delete();
        for (int k = 0; k < 4; k++) begin
            vec = rand_word();
            vec[7:0] = k[0] ? 8'h7C : 8'h01;
            cycle(1'b1, vec, k[0], 1'b1);
        end
        repeat (LAT + 1) cycle(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            ent = emit_log[k];
            check("alt_lane0", {120'b0, ent[7:0]},
                  k[0] ? (INV_EN ? 128'h01 : 128'h10) : 128'h7C);
            check("alt_mode", {127'b0, ent[W]}, (INV_EN && k[0]) ? 128'd1 : 128'd0);
        end

        // Random traffic with random stalls and modes.
        for (int k = 0; k < 400; k++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_word(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0));
        end
        repeat (LAT + 2) cycle(1'b0, '0, 1'b0, 1'b1);

        // Reset while full: nothing in flight may survive.
        repeat (LAT + 1) cycle(1'b1, rand_word(), 1'b0, 1'b0);
        do_reset(1);
        n_emit = 0;
        repeat (LAT + 3) cycle(1'b0, '0, 1'b0, 1'b1);
        check("post_reset_emits", 128'(n_emit), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
